// File: rtl/ripple_count4.sv
// Purpose : up/down binary counter with load, enable and terminal-count flag, stepping on the falling clock edge.
// Latency : one falling edge from sampled load/en/up_dn/d to the new q; tc is combinational from q and up_dn.
// Backpressure: none; the counter accepts a new command on every falling edge.
//
// Ports:
//   clock    counter clock; all state changes on the falling edge
//   clear_n  asynchronous active-low clear; forces q to RESET_VAL immediately
//   en       count enable (1 = step, 0 = hold)
//   up_dn    direction (1 = increment, 0 = decrement)
//   load     synchronous parallel load, takes priority over en
//   d        parallel load value
//   q        current count, driven straight from flops
//   tc       terminal count: q == all-ones when counting up, q == 0 when counting down
//
// Build option: define COUNTER_SATURATE_EN to make the counter stick at the
// end of its range instead of wrapping. Without it, counting wraps modulo 2^WIDTH.
//
// WIDTH must be at least 2.

module ripple_count4 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] next_val;
  logic             at_top;
  logic             at_bottom;

  // End-of-range detection, shared by the terminal-count flag and by the
  // saturating build.
  assign at_top    = (count_q == ALL_ONES);
  assign at_bottom = (count_q == ALL_ZERO);

  // Plain modulo-2^WIDTH neighbours; the natural overflow of WIDTH-bit
  // arithmetic gives the 15->0 and 0->15 wrap for free.
  assign inc_val = count_q + ONE;
  assign dec_val = count_q - ONE;

`ifdef COUNTER_SATURATE_EN
  // Saturating build: stick at the end of the range in the counting direction.
  always_comb begin
    step_val = count_q;
    if (up_dn) begin
      step_val = at_top ? count_q : inc_val;
    end else begin
      step_val = at_bottom ? count_q : dec_val;
    end
  end
`else
  // Wrapping build: silent modulo wrap in both directions.
  always_comb begin
    step_val = count_q;
    if (up_dn) begin
      step_val = inc_val;
    end else begin
      step_val = dec_val;
    end
  end
`endif

  // Command priority: load beats count, count beats hold.
  always_comb begin
    next_val = count_q;
    if (load) begin
      next_val = d;
    end else if (en) begin
      next_val = step_val;
    end
  end

  // Single bank of falling-edge flops rather than a toggle-flop ripple chain,
  // so q never shows intermediate carry states. The clear is asynchronous and
  // overrides everything, including an in-progress clock phase.
  always_ff @(negedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= next_val;
    end
  end

  assign q = count_q;

  // Combinational on purpose: follows q immediately, including right after an
  // asynchronous clear. May glitch while up_dn changes.
  assign tc = up_dn ? at_top : at_bottom;

endmodule

// File: tb/tb_ripple_count4.sv
// Purpose : self-checking bench for ripple_count4 with a behavioural model and a few fixed time-point expectations.
// Latency : model updates on each falling edge; outputs compared 5 time units after every falling edge.
// Backpressure: not applicable.

module tb_ripple_count4;

  localparam int WIDTH = 4;
  localparam int MODV  = 1 << WIDTH;
  localparam int MAXV  = MODV - 1;
  localparam int RVAL  = 0;

  logic             clock;
  logic             clear_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;

  int n_checks = 0;
  int n_fail   = 0;
  int m;             // model count as a plain integer

  ripple_count4 #(.WIDTH(WIDTH), .RESET_VAL(RVAL[WIDTH-1:0])) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .d       (d),
    .q       (q),
    .tc      (tc)
  );

  // Falling edges at 20, 40, 60, ...; rising edges at 10, 30, 50, ...
  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int model_next(input int cur, input bit ld, input int dv,
                                    input bit e, input bit up);
    int r;
    r = cur;
    if (ld) r = dv;
    else if (e) begin
`ifdef COUNTER_SATURATE_EN
      if (up) r = (cur == MAXV) ? MAXV : cur + 1;
      else    r = (cur == 0)    ? 0    : cur - 1;
`else
      if (up) r = (cur + 1) % MODV;
      else    r = (cur + MODV - 1) % MODV;
`endif
    end
    return r;
  endfunction

  function automatic bit model_tc(input int cur, input bit up);
    return up ? (cur == MAXV) : (cur == 0);
  endfunction

  // Behavioural model: clear is immediate, otherwise one update per falling edge.
  initial m = RVAL;
  always @(negedge clear_n) m = RVAL;
  always @(negedge clock) begin
    if (clear_n !== 1'b1) m = RVAL;
    else m = model_next(m, load, int'(d), en, up_dn);
  end

  // Continuous comparison, mid-way through the low phase.
  always @(negedge clock) begin
    #5;
    check("model_q", 8'(q), 8'(m));
    check("model_tc", 8'(tc), 8'(model_tc(m, up_dn)));
  end

  task automatic wait_until(input int t);
    if ($time < t) #(t - $time);
  endtask

  initial begin
    clear_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; d = '0;

    // Reset and first count
    wait_until(33);  check("reset_q", 8'(q), 8'd0);
    wait_until(34);  clear_n = 1'b1;
    wait_until(36);  check("release_no_step", 8'(q), 8'd0);
    wait_until(45);  check("first_count", 8'(q), 8'd1);
    wait_until(65);  check("second_count", 8'(q), 8'd2);
    wait_until(225); check("mid_count", 8'(q), 8'd10);

    // Mid-count async clear while the clock is high (no edge near t=234)
    wait_until(234); clear_n = 1'b0;
    wait_until(235); check("async_clear_q", 8'(q), 8'd0);
    check("async_clear_tc", 8'(tc), 8'd0);
    wait_until(283); check("clear_held", 8'(q), 8'd0);
    wait_until(284); clear_n = 1'b1;
    wait_until(285); check("clear_release", 8'(q), 8'd0);
    wait_until(305); check("first_after_clear", 8'(q), 8'd1);

    // Wrap: 1 at edge 300, so 15 at edge 580, 0 at edge 600
    wait_until(585); check("reach_max_q", 8'(q), 8'd15);
    check("reach_max_tc", 8'(tc), 8'd1);
    wait_until(605); check("wrap_q", 8'(q), 8'd0);
    check("wrap_tc", 8'(tc), 8'd0);

    // Load then count down
    wait_until(610); load = 1'b1; d = 4'd3;
    wait_until(625); check("load_3", 8'(q), 8'd3);
    wait_until(630); load = 1'b0; up_dn = 1'b0;
    wait_until(645); check("down_2", 8'(q), 8'd2);
    wait_until(665); check("down_1", 8'(q), 8'd1);
    wait_until(685); check("down_0", 8'(q), 8'd0);
    check("down_0_tc", 8'(tc), 8'd1);
    wait_until(705); check("down_wrap", 8'(q), 8'd15);

    // Hold across three edges, then load beats enable
    wait_until(710); en = 1'b0;
    wait_until(765); check("hold_q", 8'(q), 8'd15);
    check("hold_tc", 8'(tc), 8'd0);
    wait_until(770); en = 1'b1; load = 1'b1; d = 4'd9;
    wait_until(785); check("load_priority", 8'(q), 8'd9);

    // End-of-range behaviour up and down
    wait_until(790); load = 1'b1; d = 4'd14; up_dn = 1'b1;
    wait_until(810); load = 1'b0;
    wait_until(825); check("top_step", 8'(q), 8'd15);
`ifdef COUNTER_SATURATE_EN
    wait_until(845); check("sat_hold_top", 8'(q), 8'd15);
    check("sat_top_tc", 8'(tc), 8'd1);
`else
    wait_until(845); check("top_wrap", 8'(q), 8'd0);
    check("top_wrap_tc", 8'(tc), 8'd0);
`endif
    wait_until(850); load = 1'b1; d = 4'd1; up_dn = 1'b0;
    wait_until(870); load = 1'b0;
    wait_until(885); check("bottom_step", 8'(q), 8'd0);
`ifdef COUNTER_SATURATE_EN
    wait_until(905); check("sat_hold_bottom", 8'(q), 8'd0);
    check("sat_bottom_tc", 8'(tc), 8'd1);
`else
    wait_until(905); check("bottom_wrap", 8'(q), 8'd15);
`endif

    // Randomised phase: inputs change on rising edges, occasional clears
    // asserted and released between edges.
    wait_until(910);
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      up_dn = $urandom_range(0, 1);
      load  = ($urandom_range(0, 7) == 0);
      d     = WIDTH'($urandom_range(0, MAXV));
      if (clear_n == 1'b0) begin
        #3 clear_n = 1'b1;
        #17;
      end else if ($urandom_range(0, 15) == 0) begin
        #3 clear_n = 1'b0;
        #1 check("rand_async_clear", 8'(q), 8'(RVAL));
        #16;
      end else begin
        #20;
      end
    end
    clear_n = 1'b1;
    #40;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
